// File: rtl/msi_pkg.sv
// Shared encodings for the MSI cache controller: datapath op codes,
// line state codes and the controller state enum.
package msi_pkg;

  localparam logic [1:0] FUNC_PRD = 2'b00;
  localparam logic [1:0] FUNC_PWR = 2'b01;
  localparam logic [1:0] FUNC_BRD = 2'b10;
  localparam logic [1:0] FUNC_BWR = 2'b11;

  localparam logic [1:0] ST_M = 2'b11;
  localparam logic [1:0] ST_S = 2'b10;
  localparam logic [1:0] ST_I = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_ARB    = 3'd2,
    S_WB     = 3'd3,
    S_FILL   = 3'd4,
    S_WRITE  = 3'd5,
    S_RESP   = 3'd6,
    S_ERR    = 3'd7
  } ctrl_state_t;

  // States in which the controller waits on memory and the timeout runs.
  function automatic logic is_mem_state(input ctrl_state_t s);
    return (s == S_WB) || (s == S_FILL);
  endfunction

endpackage

// File: rtl/msi_timeout_ctr.sv
// Memory-wait watchdog: clear has priority over enable, tc flags the
// terminal count so the controller can abort a stuck bus transfer.
module msi_timeout_ctr #(
  parameter int CW       = 5,
  parameter int TERMINAL = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == CW'(TERMINAL));

endmodule

// File: rtl/msi_cache_ctrl.sv
// Per-cache MSI controller FSM: looks up CPU requests, arbitrates for the
// shared bus on a miss or S->M upgrade, writes back / fills, then acks.
module msi_cache_ctrl
  import msi_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CW          = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  output logic       cpu_ack,
  output logic       cpu_err,
  input  logic       read_hit,
  input  logic       write_hit,
  input  logic [1:0] stat,
  output logic       bus_req,
  input  logic       bus_grant,
  input  logic       mem_ready,
  output logic [1:0] func,
  output logic       snoop_out,
  output logic       busy
);

  ctrl_state_t state_reg, state_next;
  logic        we_reg, we_next;
  logic        upg_reg, upg_next;
  logic        owned_reg, owned_next;
  logic        stall;
  logic        tmr_clear;
  logic        tmr_enable;
  logic        tmr_tc;

  msi_timeout_ctr #(
    .CW       (CW),
    .TERMINAL (MEM_TIMEOUT - 1)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .tc     (tmr_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      we_reg    <= 1'b0;
      upg_reg   <= 1'b0;
      owned_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      upg_reg   <= upg_next;
      owned_reg <= owned_next;
    end
  end

  // Losing the grant while we own the bus freezes any bus-side datapath op.
  assign stall      = owned_reg && !bus_grant;
  assign tmr_enable = is_mem_state(state_reg);
  assign tmr_clear  = is_mem_state(state_next) && (state_next != state_reg);
  assign busy       = (state_reg != S_IDLE);

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    upg_next   = upg_reg;
    owned_next = owned_reg;
    func       = FUNC_PRD;
    cpu_ack    = 1'b0;
    cpu_err    = 1'b0;
    bus_req    = 1'b0;
    snoop_out  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        owned_next = 1'b0;
        upg_next   = 1'b0;
        if (cpu_req) begin
          we_next    = cpu_we;
          state_next = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        bus_req = owned_reg;
        if (!we_reg && read_hit) begin
          state_next = S_RESP;
        end else if (we_reg && write_hit) begin
          state_next = S_WRITE;
        end else begin
          upg_next   = we_reg && read_hit;
          state_next = S_ARB;
        end
      end

      S_ARB: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          owned_next = 1'b1;
          if (upg_reg) begin
            state_next = S_WRITE;
          end else if (stat == ST_M) begin
            state_next = S_WB;
          end else begin
            state_next = S_FILL;
          end
        end
      end

      S_WB: begin
        bus_req = 1'b1;
        func    = stall ? FUNC_PRD : FUNC_BWR;
        if (!stall && mem_ready) begin
          state_next = S_FILL;
        end else if (tmr_tc) begin
          state_next = S_ERR;
        end
      end

      S_FILL: begin
        bus_req   = 1'b1;
        func      = stall ? FUNC_PRD : FUNC_BRD;
        snoop_out = !stall;
        if (!stall && mem_ready) begin
          state_next = S_LOOKUP;
        end else if (tmr_tc) begin
          state_next = S_ERR;
        end
      end

      S_WRITE: begin
        bus_req = owned_reg;
        if (!stall) begin
          func       = FUNC_PWR;
          state_next = S_RESP;
        end
      end

      S_RESP: begin
        bus_req    = owned_reg;
        cpu_ack    = 1'b1;
        state_next = S_IDLE;
      end

      S_ERR: begin
        cpu_ack    = 1'b1;
        cpu_err    = 1'b1;
        owned_next = 1'b0;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
